l_tree: RTL and testbench

//  Compresses the WOTS_LEN public-key chain ends written by gen_pk into one XMSS leaf via the L-tree.

---
 rtl/l_tree.sv | 205 ++++++++++++++++++++
 tb/tb_l_tree.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l_tree.sv
// rtl/l_tree.sv - WOTS public-key L-tree compression into one XMSS leaf
//
// Purpose: folds the WOTS_LEN chain ends held in the shared node memory into
// one L-tree root. Pairs of nodes are hashed through an external thash_h unit.
// Each parent is written back in place. An odd trailing node is promoted to the
// next level without a hash.
//
// Ports:
//   clk, reset              clock; synchronous active-high reset
//   start, hash_addr        run request and caller address (type/ltree words preset)
//   busy, done              run in progress / one-cycle completion pulse
//   leaf_out, hash_addr_out L-tree root and the address used for the final hash
//   mem_rd_*, mem_wr_*      node memory ports (read data returns one cycle later)
//   thash_*                 request/response handshake to the thash_h unit
module l_tree #(
  parameter int  WOTS_LEN = 67,
  parameter int  KEY_LEN  = 256,
  localparam int ADDR_W   = $clog2(WOTS_LEN)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [255:0]       hash_addr,
  output logic               busy,
  output logic               done,
  output logic [KEY_LEN-1:0] leaf_out,
  output logic [255:0]       hash_addr_out,
  output logic               mem_rd_en,
  output logic [ADDR_W-1:0]  mem_rd_addr,
  input  logic [KEY_LEN-1:0] mem_rd_data,
  output logic               mem_wr_en,
  output logic [ADDR_W-1:0]  mem_wr_addr,
  output logic [KEY_LEN-1:0] mem_wr_data,
  output logic               thash_start,
  output logic [KEY_LEN-1:0] thash_left,
  output logic [KEY_LEN-1:0] thash_right,
  output logic [255:0]       thash_addr,
  input  logic               thash_done,
  input  logic [KEY_LEN-1:0] thash_data_out
);

  // l must hold WOTS_LEN itself, so it may need one bit more than a node index
  localparam int CNT_W = $clog2(WOTS_LEN + 1);
  // clears the tree-height word [95:64] and tree-index word [63:32]
  localparam logic [255:0] ADDR_MASK = ~({192'd0, 64'hFFFF_FFFF_FFFF_FFFF} << 32);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_L,
    S_RD_R,
    S_CAP,
    S_HASH,
    S_WAIT,
    S_WR,
    S_ODD_RD,
    S_ODD_WR,
    S_LVL,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [CNT_W-1:0]   l;
  logic [ADDR_W-1:0]  i;
  logic [31:0]        height;
  logic [KEY_LEN-1:0] left_r;
  logic [KEY_LEN-1:0] right_r;
  logic [KEY_LEN-1:0] res;
  logic [255:0]       addr_r;

  logic [CNT_W-1:0]   l_half;
  logic [CNT_W-1:0]   l_next;
  logic               pair_more;

  assign l_half    = l >> 1;
  // ceil(l/2) computed one bit wider so that l+1 cannot overflow
  assign l_next    = CNT_W'(({1'b0, l} + {{CNT_W{1'b0}}, 1'b1}) >> 1);
  assign pair_more = (CNT_W'(i) + CNT_W'(1)) < l_half;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      l             <= '0;
      i             <= '0;
      height        <= '0;
      left_r        <= '0;
      right_r       <= '0;
      res           <= '0;
      addr_r        <= '0;
      leaf_out      <= '0;
      hash_addr_out <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (start) begin
            l      <= CNT_W'(WOTS_LEN);
            i      <= '0;
            height <= '0;
            addr_r <= hash_addr & ADDR_MASK;
          end
        end
        // read data for the left child (issued in S_RD_L) lands here
        S_RD_R: left_r <= mem_rd_data;
        S_CAP: begin
          right_r        <= mem_rd_data;
          addr_r[95:64]  <= height;
          addr_r[63:32]  <= 32'(i);
        end
        S_WAIT: begin
          if (thash_done) begin
            res <= thash_data_out;
          end
        end
        S_WR: begin
          if (pair_more) begin
            i <= i + ADDR_W'(1);
          end
        end
        S_LVL: begin
          l      <= l_next;
          height <= height + 32'd1;
          i      <= '0;
          // capture the root on entry to S_DONE so it is valid in the done cycle
          if (l_next == CNT_W'(1)) begin
            leaf_out      <= res;
            hash_addr_out <= addr_r;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx    = state;
    mem_rd_en   = 1'b0;
    mem_rd_addr = '0;
    mem_wr_en   = 1'b0;
    mem_wr_addr = '0;
    mem_wr_data = '0;
    thash_start = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = S_RD_L;
        end
      end
      S_RD_L: begin
        mem_rd_en   = 1'b1;
        mem_rd_addr = ADDR_W'({i, 1'b0});
        state_nx    = S_RD_R;
      end
      S_RD_R: begin
        mem_rd_en   = 1'b1;
        mem_rd_addr = ADDR_W'({i, 1'b1});
        state_nx    = S_CAP;
      end
      S_CAP: state_nx = S_HASH;
      S_HASH: begin
        thash_start = 1'b1;
        state_nx    = S_WAIT;
      end
      S_WAIT: begin
        if (thash_done) begin
          state_nx = S_WR;
        end
      end
      S_WR: begin
        mem_wr_en   = 1'b1;
        mem_wr_addr = i;
        mem_wr_data = res;
        if (pair_more) begin
          state_nx = S_RD_L;
        end else if (l[0]) begin
          state_nx = S_ODD_RD;
        end else begin
          state_nx = S_LVL;
        end
      end
      S_ODD_RD: begin
        mem_rd_en   = 1'b1;
        mem_rd_addr = ADDR_W'(l - CNT_W'(1));
        state_nx    = S_ODD_WR;
      end
      // the unpaired last node moves to slot l>>1 of the next level
      S_ODD_WR: begin
        mem_wr_en   = 1'b1;
        mem_wr_addr = ADDR_W'(l_half);
        mem_wr_data = mem_rd_data;
        state_nx    = S_LVL;
      end
      S_LVL:   state_nx = (l_next == CNT_W'(1)) ? S_DONE : S_RD_L;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign busy        = (state != S_IDLE) && (state != S_DONE);
  assign done        = (state == S_DONE);
  assign thash_left  = left_r;
  assign thash_right = right_r;
  assign thash_addr  = addr_r;

endmodule

// File: tb/tb_l_tree.sv
// tb/tb_l_tree.sv - self-checking bench for l_tree at WOTS_LEN 2, 5 and 67
module tb_l_tree;

  localparam int NDUT = 3;
  localparam int ELEN = 128;

  function automatic int len_of(input int k);
    return (k == 0) ? 2 : (k == 1) ? 5 : 67;
  endfunction

  // bench hash: non-commutative and dependent on height and index
  function automatic logic [255:0] hf(input logic [255:0] a, input logic [255:0] b,
                                      input logic [255:0] ad);
    return {a[248:0], a[255:249]} ^ (b + ad) ^ {8{ad[95:64] ^ ad[63:32] ^ 32'h5A5A_0F0F}};
  endfunction

  function automatic logic [255:0] rnd256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  logic         clk;
  logic         reset;
  logic [255:0] hash_addr;
  logic         start    [NDUT];
  logic         busy     [NDUT];
  logic         done     [NDUT];
  logic [255:0] leaf     [NDUT];
  logic [255:0] hao      [NDUT];
  logic         rd_en_a  [NDUT];
  logic         wr_en_a  [NDUT];
  logic         ts_a     [NDUT];
  logic         ld_en    [NDUT];
  logic         spur     [NDUT];
  logic         clr      [NDUT];
  int           hcnt_a   [NDUT];
  int           mis_a    [NDUT];
  int           wcnt_a   [NDUT];
  int           clash_a  [NDUT];
  int           ld_idx;
  logic [255:0] ld_data;
  int unsigned  maxd;
  logic [255:0] exp_l [NDUT][ELEN];
  logic [255:0] exp_r [NDUT][ELEN];
  logic [255:0] exp_a [NDUT][ELEN];

  int errors;
  int checks;
  int cur_v;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int L  = len_of(g);
    localparam int AW = $clog2(L);
    logic [AW-1:0] rd_addr, wr_addr;
    logic [255:0]  rd_data, wr_data, tl, tr, ta, tdo, hres;
    logic          td;
    int            dly, hcnt, mis, wcnt, clash;
    bit            pend;
    logic [255:0]  m [L];

    l_tree #(.WOTS_LEN(L), .KEY_LEN(256)) dut (
      .clk(clk), .reset(reset), .start(start[g]), .hash_addr(hash_addr),
      .busy(busy[g]), .done(done[g]), .leaf_out(leaf[g]), .hash_addr_out(hao[g]),
      .mem_rd_en(rd_en_a[g]), .mem_rd_addr(rd_addr), .mem_rd_data(rd_data),
      .mem_wr_en(wr_en_a[g]), .mem_wr_addr(wr_addr), .mem_wr_data(wr_data),
      .thash_start(ts_a[g]), .thash_left(tl), .thash_right(tr), .thash_addr(ta),
      .thash_done(td | spur[g]), .thash_data_out(tdo)
    );

    initial begin
      td = 1'b0; tdo = '0; hres = '0; pend = 1'b0; dly = 0;
      hcnt = 0; mis = 0; wcnt = 0; clash = 0; rd_data = '0;
    end

    // node memory, thash_h responder and per-run observation counters
    always @(posedge clk) begin
      td <= 1'b0;
      if (ld_en[g]) m[AW'(ld_idx)] <= ld_data;
      if (rd_en_a[g]) rd_data <= m[rd_addr];
      if (wr_en_a[g]) begin
        m[wr_addr] <= wr_data;
        wcnt <= wcnt + 1;
      end
      if (rd_en_a[g] && wr_en_a[g]) clash <= clash + 1;
      if (reset) begin
        pend <= 1'b0;
      end else if (ts_a[g]) begin
        if (hcnt > ELEN - 1) mis <= mis + 1;
        else if (tl !== exp_l[g][hcnt[6:0]] || tr !== exp_r[g][hcnt[6:0]] ||
                 ta !== exp_a[g][hcnt[6:0]]) mis <= mis + 1;
        hcnt <= hcnt + 1;
        hres <= hf(tl, tr, ta);
        dly  <= int'($urandom_range(maxd, 32'd1));
        pend <= 1'b1;
      end else if (pend) begin
        if (dly <= 1) begin
          td   <= 1'b1;
          tdo  <= hres;
          pend <= 1'b0;
        end else begin
          dly <= dly - 1;
        end
      end
      if (clr[g]) begin
        hcnt <= 0; mis <= 0; wcnt <= 0; clash <= 0;
      end
    end

    assign hcnt_a[g]  = hcnt;
    assign mis_a[g]   = mis;
    assign wcnt_a[g]  = wcnt;
    assign clash_a[g] = clash;
  end

  typedef struct {
    int          d;
    int          pat;
    int unsigned maxd;
    bit          extra;
    bit          spur;
    int          exp_h;
    int          exp_ht;
  } vec_t;
  vec_t tbl [6];

  logic [255:0] root_e, fa_e;
  int           nwr_e;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (vec %0d): got %h want %h", nm, cur_v, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s (vec %0d): got %0d want %0d", nm, cur_v, act, exp);
    end
  endtask

  // loads memory and computes the L-tree level by level from plain lists
  task automatic load_and_model(input int d, input int pat);
    logic [255:0] cur[$], nxt[$], a, nd;
    int L, nh, h;
    L = len_of(d);
    for (int k = 0; k < L; k++) begin
      nd = (pat == 1) ? {8{32'hA0 + 32'(k)}} : rnd256();
      cur.push_back(nd);
      ld_en[d] = 1'b1; ld_idx = k; ld_data = nd;
      @(posedge clk); #1;
    end
    ld_en[d] = 1'b0;
    nh = 0; nwr_e = 0; h = 0; fa_e = '0;
    while (cur.size() > 1) begin
      nxt.delete();
      for (int k = 0; k + 1 < cur.size(); k += 2) begin
        a = hash_addr;
        a[95:64] = h;
        a[63:32] = k / 2;
        exp_l[d][nh] = cur[k];
        exp_r[d][nh] = cur[k+1];
        exp_a[d][nh] = a;
        nxt.push_back(hf(cur[k], cur[k+1], a));
        nh++; nwr_e++; fa_e = a;
      end
      if (cur.size() % 2 == 1) begin
        nxt.push_back(cur[cur.size()-1]);
        nwr_e++;
      end
      cur = nxt;
      h++;
    end
    root_e = cur[0];
    clr[d] = 1'b1;
    @(posedge clk); #1;
    clr[d] = 1'b0;
  endtask

  task automatic run_tree(input int v);
    int d, ndone;
    bit fin;
    cur_v = v;
    d = tbl[v].d;
    maxd = tbl[v].maxd;
    hash_addr = rnd256();
    load_and_model(d, tbl[v].pat);
    start[d] = 1'b1;
    @(posedge clk); #1;
    start[d] = 1'b0;
    chki("busy_after_start", int'(busy[d]), 1);
    fin = 1'b0;
    for (int c = 0; c < 20000 && !fin; c++) begin
      if (done[d]) begin
        fin = 1'b1;
      end else begin
        start[d] = tbl[v].extra && (c == 6);
        spur[d]  = tbl[v].spur && (c == 0);
        @(posedge clk); #1;
        start[d] = 1'b0;
        spur[d]  = 1'b0;
      end
    end
    chki("done_reached", int'(fin), 1);
    chk("leaf_out", leaf[d], root_e);
    chk("hash_addr_out", hao[d], fa_e);
    chki("final_height", int'(hao[d][95:64]), tbl[v].exp_ht);
    chki("hash_count", hcnt_a[d], tbl[v].exp_h);
    chki("hash_order_mismatches", mis_a[d], 0);
    chki("mem_writes", wcnt_a[d], nwr_e);
    chki("rd_wr_same_cycle", clash_a[d], 0);
    ndone = 0;
    for (int c = 0; c < 4; c++) begin
      if (done[d]) ndone++;
      @(posedge clk); #1;
    end
    chki("done_pulses", ndone, 1);
    chki("busy_after_done", int'(busy[d]), 0);
  endtask

  initial begin
    int w0;
    bit hit;
    errors = 0; checks = 0; cur_v = -1;
    reset = 1'b1; hash_addr = '0; maxd = 1; ld_idx = 0; ld_data = '0;
    for (int d = 0; d < NDUT; d++) begin
      start[d] = 1'b0; ld_en[d] = 1'b0; spur[d] = 1'b0; clr[d] = 1'b0;
    end
    tbl[0] = '{d: 0, pat: 1, maxd: 1,   extra: 0, spur: 0, exp_h: 1,  exp_ht: 0};
    tbl[1] = '{d: 0, pat: 0, maxd: 20,  extra: 0, spur: 0, exp_h: 1,  exp_ht: 0};
    tbl[2] = '{d: 1, pat: 1, maxd: 3,   extra: 0, spur: 1, exp_h: 4,  exp_ht: 2};
    tbl[3] = '{d: 1, pat: 0, maxd: 50,  extra: 1, spur: 0, exp_h: 4,  exp_ht: 2};
    tbl[4] = '{d: 2, pat: 0, maxd: 100, extra: 0, spur: 0, exp_h: 66, exp_ht: 6};
    tbl[5] = '{d: 2, pat: 0, maxd: 5,   extra: 1, spur: 1, exp_h: 66, exp_ht: 6};

    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) begin
      chki("reset_busy", int'(busy[d]), 0);
      chki("reset_done", int'(done[d]), 0);
      chki("reset_strobes", int'({rd_en_a[d], wr_en_a[d], ts_a[d]}), 0);
      chk("reset_leaf", leaf[d], '0);
      chk("reset_hash_addr_out", hao[d], '0);
    end
    reset = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 6; v++) run_tree(v);

    // spurious thash_done while idle
    cur_v = 10;
    w0 = wcnt_a[1];
    spur[1] = 1'b1;
    @(posedge clk); #1;
    spur[1] = 1'b0;
    @(posedge clk); #1;
    chki("idle_spur_busy", int'(busy[1]), 0);
    chki("idle_spur_done", int'(done[1]), 0);
    chki("idle_spur_writes", wcnt_a[1], w0);

    // start coincident with reset: reset wins
    cur_v = 11;
    reset = 1'b1; start[0] = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; start[0] = 1'b0;
    chki("reset_start_busy", int'(busy[0]), 0);
    @(posedge clk); #1;
    chki("reset_start_busy_later", int'(busy[0]), 0);

    // reset while waiting for thash_done, then a fresh run
    cur_v = 12;
    maxd = 100;
    hash_addr = rnd256();
    load_and_model(2, 0);
    start[2] = 1'b1;
    @(posedge clk); #1;
    start[2] = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 300 && !hit; c++) begin
      if (hcnt_a[2] > 0) hit = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    chki("reached_wait", int'(hit), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    chki("abort_busy", int'(busy[2]), 0);
    chki("abort_done", int'(done[2]), 0);
    chki("abort_strobes", int'({rd_en_a[2], wr_en_a[2], ts_a[2]}), 0);
    reset = 1'b0;
    @(posedge clk); #1;
    run_tree(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
